// File: rtl/sppf_pool_stream_pkg.sv
// Shared types and helpers for the streaming SPPF pooling block.
package sppf_pkg;

    typedef enum logic [1:0] {LOAD, POOL, OUTPUT} state_t;
    typedef enum logic {H_PASS, V_PASS} pass_t;

    // Lanes are sign-extended to this width before comparison; WIDTH must not exceed it.
    localparam int unsigned LANE_W_MAX = 64;
    typedef logic signed [LANE_W_MAX-1:0] lane_wide_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed maximum of two sign-extended lanes.
    function automatic lane_wide_t smax(input lane_wide_t a, input lane_wide_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sppf_pool_stream_if.sv
// Pixel stream handshake bundle: input stream in, concatenated pool groups out.
interface sppf_pool_stream_if #(
    parameter int unsigned CH        = 1,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_POOLS = 3
);
    logic                              in_valid;
    logic                              in_ready;
    logic [CH*WIDTH-1:0]               in_data;
    logic                              out_valid;
    logic                              out_ready;
    logic [(NUM_POOLS+1)*CH*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sppf_pool_stream_lane_max_acc.sv
// CH-lane signed running-max accumulator shared by every pooling pass.
// init loads din, update takes the per-lane signed max, otherwise the value holds.
// acc_next is the value including the current tap, so the last tap can be
// written out in the same cycle it is consumed.
module lane_max_acc
    import sppf_pkg::*;
#(
    parameter int unsigned CH    = 1,
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic                update,
    input  logic [CH*WIDTH-1:0] din,
    output logic [CH*WIDTH-1:0] acc_next
);
    logic [CH*WIDTH-1:0] acc;

    // Select the accumulator's next value from the control inputs.
    always_comb begin
        acc_next = acc;
        if (init) begin
            acc_next = din;
        end else if (update) begin
            for (int unsigned c = 0; c < CH; c++) begin
                acc_next[c*WIDTH +: WIDTH] = WIDTH'(smax(
                    lane_wide_t'($signed(acc[c*WIDTH +: WIDTH])),
                    lane_wide_t'($signed(din[c*WIDTH +: WIDTH]))));
            end
        end
    end

    // Running accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end
endmodule

// File: rtl/sppf_pool_stream.sv
// Streaming SPPF pooling: buffer one frame, run NUM_POOLS cascaded KxK
// stride-1 same max-pools as separable H/V passes (K cycles per output pixel),
// then stream {pool_N, ..., pool_1, input} per pixel.
module sppf_pool_stream
    import sppf_pkg::*;
#(
    parameter int unsigned CH        = 1,
    parameter int unsigned IN_H      = 1,
    parameter int unsigned IN_W      = 1,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned K         = 5,
    parameter int unsigned NUM_POOLS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    sppf_pool_stream_if.slave bus,
    output logic              busy
);
    localparam int unsigned PIX  = IN_H * IN_W;
    localparam int unsigned HALF = (K - 1) / 2;
    localparam int unsigned PXW  = CH * WIDTH;
    localparam int unsigned PW   = cnt_w(PIX);
    localparam int unsigned RW   = cnt_w(IN_H);
    localparam int unsigned CW   = cnt_w(IN_W);
    localparam int unsigned TW   = cnt_w(K);
    localparam int unsigned SW   = cnt_w(NUM_POOLS + 1);

    state_t         state_q, state_d;
    pass_t          pass_q;
    logic           ready_q;
    logic [PW-1:0]  idx_q, j_q, pix_q;
    logic [RW-1:0]  row_q;
    logic [CW-1:0]  col_q;
    logic [TW-1:0]  tap_q;
    logic [SW-1:0]  stage_q;
    logic           seen_q;

    // B0 holds the input frame, B1..BN the pool results, tbank the H-pass result.
    logic [PXW-1:0] bank  [0:NUM_POOLS][0:PIX-1];
    logic [PXW-1:0] tbank [0:PIX-1];

    logic           in_fire, out_fire;
    logic           tap_last, pix_last, stage_last, pool_done;
    logic           in_range, acc_init, acc_upd;
    int             src_row, src_col;
    logic [PW-1:0]  src_a;
    logic [PXW-1:0] src_px, acc_next;

    // Handshake and sequencing flags.
    always_comb begin
        in_fire    = (state_q == LOAD) && ready_q && bus.in_valid;
        out_fire   = (state_q == OUTPUT) && bus.out_ready;
        tap_last   = (tap_q == TW'(K - 1));
        pix_last   = (pix_q == PW'(PIX - 1));
        stage_last = (stage_q == SW'(NUM_POOLS));
        pool_done  = tap_last && pix_last && (pass_q == V_PASS) && stage_last;
    end

    // Tap source address, range test (-inf padding) and source pixel fetch.
    always_comb begin
        src_row = int'(row_q);
        src_col = int'(col_q);
        if (pass_q == H_PASS) begin
            src_col = src_col + int'(tap_q) - int'(HALF);
        end else begin
            src_row = src_row + int'(tap_q) - int'(HALF);
        end
        in_range = (src_row >= 0) && (src_row < int'(IN_H)) &&
                   (src_col >= 0) && (src_col < int'(IN_W));
        src_a    = in_range ? PW'(src_row * int'(IN_W) + src_col) : '0;
        src_px   = (pass_q == H_PASS) ? bank[stage_q - SW'(1)][src_a] : tbank[src_a];
        acc_init = (state_q == POOL) && in_range && !seen_q;
        acc_upd  = (state_q == POOL) && in_range && seen_q;
    end

    lane_max_acc #(
        .CH    (CH),
        .WIDTH (WIDTH)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (acc_init),
        .update   (acc_upd),
        .din      (src_px),
        .acc_next (acc_next)
    );

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state_q)
            LOAD: begin
                bus.in_ready = ready_q;
                if (in_fire && idx_q == PW'(PIX - 1)) state_d = POOL;
            end
            POOL: begin
                busy = 1'b1;
                if (pool_done) state_d = OUTPUT;
            end
            OUTPUT: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (out_fire && j_q == PW'(PIX - 1)) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // Output concatenation for pixel j, zero outside OUTPUT.
    always_comb begin
        bus.out_data = '0;
        if (state_q == OUTPUT) begin
            for (int unsigned g = 0; g <= NUM_POOLS; g++) begin
                bus.out_data[g*PXW +: PXW] = bank[g][j_q];
            end
        end
    end

    // State, handshake counters and pass/pixel/tap sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            ready_q <= 1'b0;
            idx_q   <= '0;
            j_q     <= '0;
            pix_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            tap_q   <= '0;
            stage_q <= SW'(1);
            pass_q  <= H_PASS;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            if (in_fire) idx_q <= (idx_q == PW'(PIX - 1)) ? '0 : idx_q + 1'b1;
            if (out_fire) j_q <= (j_q == PW'(PIX - 1)) ? '0 : j_q + 1'b1;
            if (state_q == POOL) begin
                if (tap_last) begin
                    tap_q  <= '0;
                    seen_q <= 1'b0;
                    if (pix_last) begin
                        pix_q <= '0;
                        row_q <= '0;
                        col_q <= '0;
                        if (pass_q == H_PASS) begin
                            pass_q <= V_PASS;
                        end else begin
                            pass_q  <= H_PASS;
                            stage_q <= stage_last ? SW'(1) : stage_q + 1'b1;
                        end
                    end else begin
                        pix_q <= pix_q + 1'b1;
                        if (col_q == CW'(IN_W - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end else begin
                    tap_q  <= tap_q + 1'b1;
                    seen_q <= seen_q | in_range;
                end
            end
        end
    end

    // Frame storage: input capture and end-of-window result writes.
    always_ff @(posedge clk) begin
        if (in_fire) bank[0][idx_q] <= bus.in_data;
        if (state_q == POOL && tap_last) begin
            if (pass_q == H_PASS) begin
                tbank[pix_q] <= acc_next;
            end else begin
                bank[stage_q][pix_q] <= acc_next;
            end
        end
    end
endmodule
